// File: rtl/comparator_lt_signed.sv
// Registered subtract-based compare unit: difference, carry, EQ and signed LT.
// Define COMPARATOR_UNSIGNED_EN to add the registered unsigned LTU output.
module comparator_lt_signed #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             EQ,
    output logic             LT
`ifdef COMPARATOR_UNSIGNED_EN
    ,
    output logic             LTU
`endif
);

    logic [WIDTH:0]   sum;
    logic             eq_d;
    logic             lt_d;
    logic             a_s;
    logic             b_s;
    logic             s_s;

    logic             valid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             eq_q;
    logic             lt_q;

    // Single adder: A + ~B + 1; all flags derive from its result.
    always_comb begin
        sum  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        a_s  = A[WIDTH-1];
        b_s  = B[WIDTH-1];
        s_s  = sum[WIDTH-1];
        eq_d = ~|sum[WIDTH-1:0];
        lt_d = (a_s != b_s) ? a_s : (s_s & ~eq_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= sum[WIDTH-1:0];
                cout_q <= sum[WIDTH];
                eq_q   <= eq_d;
                lt_q   <= lt_d;
            end
        end
    end

`ifdef COMPARATOR_UNSIGNED_EN
    logic ltu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ltu_q <= 1'b0;
        end else if (in_valid) begin
            ltu_q <= ~sum[WIDTH];
        end
    end

    assign LTU = ltu_q;
`endif

    assign out_valid = valid_q;
    assign S         = s_q;
    assign COUT      = cout_q;
    assign EQ        = eq_q;
    assign LT        = lt_q;

endmodule

// File: tb/tb_comparator_lt_signed.sv
// Scoreboard bench for comparator_lt_signed: directed vectors,
// signed sweep, hold and mid-stream reset.
module tb_comparator_lt_signed;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        eq;
        logic        lt;
        logic        ltu;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic [31:0] S;
    logic        COUT;
    logic        EQ;
    logic        LT;
`ifdef COMPARATOR_UNSIGNED_EN
    logic        LTU;
`endif

    int checks;
    int failures;
    exp_t q[$];

    comparator_lt_signed #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .S        (S),
        .COUT     (COUT),
        .EQ       (EQ),
        .LT       (LT)
`ifdef COMPARATOR_UNSIGNED_EN
        ,
        .LTU      (LTU)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("S", S, e.s);
                chk("COUT", {31'd0, COUT}, {31'd0, e.cout});
                chk("EQ", {31'd0, EQ}, {31'd0, e.eq});
                chk("LT", {31'd0, LT}, {31'd0, e.lt});
`ifdef COMPARATOR_UNSIGNED_EN
                chk("LTU", {31'd0, LTU}, {31'd0, e.ltu});
`endif
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input exp_t e);
        @(posedge clk);
        #1;
        A = a;
        B = b;
        in_valid = 1'b1;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_S"}, S, 32'd0);
        chk({tag, "_flags"}, {28'd0, out_valid, COUT, EQ, LT},
            32'd0);
`ifdef COMPARATOR_UNSIGNED_EN
        chk({tag, "_LTU"}, {31'd0, LTU}, 32'd0);
`endif
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c,
                                input logic eq, input logic lt,
                                input logic ltu);
        exp_t e;
        e.s = s;
        e.cout = c;
        e.eq = eq;
        e.lt = lt;
        e.ltu = ltu;
        return e;
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        #2;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(32'd5, 32'd5, mk(32'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        drive(32'hFFFFFFFF, 32'd0,
              mk(32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0));
        drive(32'h7FFFFFFF, 32'h80000000,
              mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1));
        drive(32'h80000000, 32'h7FFFFFFF,
              mk(32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0));

        drive(32'd3, 32'd7, mk(32'hFFFFFFFC, 1'b0, 1'b0, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 32'd9;
        B = 32'd1;
        @(posedge clk);
        #2;
        chk("hold_S", S, 32'hFFFFFFFC);
        chk("hold_LT", {31'd0, LT}, 32'd1);
        chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
        idle(1);

        for (int i = -128; i < 128; i++) begin
            for (int j = -128; j < 128; j++) begin
                logic [31:0] a;
                logic [31:0] b;
                logic [31:0] d;
                a = i;
                b = j;
                d = i - j;
                drive(a, b, mk(d, a >= b, i == j, i < j, a < b));
            end
        end
        idle(2);

        drive(32'd1, 32'd2, mk(32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1));
        drive(32'd4, 32'd4, mk(32'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk_zero("midreset");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("held_reset");
        rst_n = 1'b1;
        drive(32'd10, 32'hFFFFFFFD,
              mk(32'd13, 1'b0, 1'b0, 1'b0, 1'b1));
        idle(3);
        chk("queue_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
